// File: rtl/algo_fque_pfbuf.sv
`default_nettype none
// algo_fque_pfbuf: keeps up to PFDEPTH free pointers popped ahead of demand,
// registers client returns onto the push port, and flushes prefetched pointers back.
module algo_fque_pfbuf #(
  parameter int BITQPTR  = 4,
  parameter int BITQCNT  = 5,
  parameter int PFDEPTH  = 4,
  parameter int BITPFCNT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fq_ready,
  input  logic [BITQCNT-1:0]  freecnt,
  output logic                pop,
  input  logic                po_pvld,
  input  logic [BITQPTR-1:0]  po_ptr,
  output logic                push,
  output logic [BITQPTR-1:0]  pu_ptr,
  output logic                alloc_vld,
  output logic [BITQPTR-1:0]  alloc_ptr,
  input  logic                alloc_req,
  input  logic                free_req,
  input  logic [BITQPTR-1:0]  free_ptr,
  input  logic                flush,
  output logic                busy,
  output logic [BITPFCNT-1:0] pf_cnt,
  output logic                err
);
  localparam int AW = (PFDEPTH > 1) ? $clog2(PFDEPTH) : 1;
  localparam int SW = BITPFCNT + 1;
  localparam int CW = (BITQCNT > BITPFCNT) ? BITQCNT : BITPFCNT;

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]          state, state_nx;
  logic [BITPFCNT-1:0] inflight, inflight_nx, cnt_nx;
  logic [AW-1:0]       rd_ptr, wr_ptr, rd_nx, wr_nx;
  logic [BITQPTR-1:0]  mem [PFDEPTH];
  logic [BITQPTR-1:0]  head_nx;
  logic [SW-1:0]       occ;
  logic                deq, fl_deq, pull, room, enq, ret_ok, po_bad;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(PFDEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_INIT;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:  if (fq_ready) state_nx = S_RUN;
      S_RUN:   if (flush) state_nx = S_FLUSH;
      S_FLUSH: if (pf_cnt == '0 && inflight == '0) state_nx = S_RUN;
      default: state_nx = S_INIT;
    endcase
  end

  assign occ = SW'(pf_cnt) + SW'(inflight);

  // Flush drains only once every outstanding pop has landed, and yields to client returns.
  always_comb begin
    busy   = (state == S_FLUSH);
    pop    = (state == S_RUN) & fq_ready & (occ < SW'(PFDEPTH)) & (CW'(freecnt) > CW'(inflight));
    fl_deq = (state == S_FLUSH) & (inflight == '0) & (pf_cnt != '0) & ~free_req;
  end

  always_comb begin
    deq         = alloc_req & alloc_vld;
    pull        = deq | fl_deq;
    room        = (pf_cnt != BITPFCNT'(PFDEPTH)) | pull;
    ret_ok      = po_pvld & (inflight != '0);
    enq         = ret_ok & room;
    po_bad      = po_pvld & ~enq;
    rd_nx       = pull ? wrap_inc(rd_ptr) : rd_ptr;
    wr_nx       = enq ? wrap_inc(wr_ptr) : wr_ptr;
    cnt_nx      = pf_cnt + BITPFCNT'(enq) - BITPFCNT'(pull);
    inflight_nx = inflight + BITPFCNT'(pop) - BITPFCNT'(ret_ok);
    // The new head is the pointer being written when the FIFO is otherwise empty.
    head_nx     = (enq && rd_nx == wr_ptr) ? po_ptr : mem[rd_nx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      pf_cnt    <= '0;
      alloc_vld <= 1'b0;
      alloc_ptr <= '0;
      push      <= 1'b0;
      pu_ptr    <= '0;
      err       <= 1'b0;
    end else begin
      inflight  <= inflight_nx;
      rd_ptr    <= rd_nx;
      wr_ptr    <= wr_nx;
      pf_cnt    <= cnt_nx;
      alloc_vld <= (cnt_nx != '0) & (state_nx == S_RUN);
      alloc_ptr <= head_nx;
      push      <= free_req | fl_deq;
      if (free_req)    pu_ptr <= free_ptr;
      else if (fl_deq) pu_ptr <= mem[rd_ptr];
      err       <= err | po_bad | (alloc_req & ~alloc_vld);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= po_ptr;
  end

endmodule
`default_nettype wire

// File: tb/tb_algo_fque_pfbuf.sv
`default_nettype none
// Bench for algo_fque_pfbuf: vector table, directed multi-cycle sequences and
// randomized traffic against a queue-based model with an emulated free queue.
module tb_algo_fque_pfbuf;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       fq_ready, pop, po_pvld, push, alloc_vld, alloc_req, free_req, flush, busy, err;
  logic [4:0] freecnt;
  logic [3:0] po_ptr, pu_ptr, alloc_ptr, free_ptr;
  logic [2:0] pf_cnt;

  always #5 clk = ~clk;

  algo_fque_pfbuf #(.BITQPTR(4), .BITQCNT(5), .PFDEPTH(P), .BITPFCNT(3)) dut (
    .clk(clk), .rst(rst), .fq_ready(fq_ready), .freecnt(freecnt), .pop(pop),
    .po_pvld(po_pvld), .po_ptr(po_ptr), .push(push), .pu_ptr(pu_ptr),
    .alloc_vld(alloc_vld), .alloc_ptr(alloc_ptr), .alloc_req(alloc_req),
    .free_req(free_req), .free_ptr(free_ptr), .flush(flush), .busy(busy),
    .pf_cnt(pf_cnt), .err(err)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       fq;
    logic [4:0] fc;
    logic       areq;
    logic       freq;
    logic [3:0] fptr;
    logic       pv;
    logic [3:0] pptr;
    logic       e_pop;
    logic       e_vld;
    logic [3:0] e_aptr;
    logic [2:0] e_cnt;
    logic       e_push;
    logic [3:0] e_pu;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int fq, fc, areq, freq, fptr, pv, pptr,
                              ep, ev, ea, ec, eps, epu, ee);
    vec_t v;
    v.fq = 1'(fq);     v.fc = 5'(fc);       v.areq = 1'(areq);  v.freq = 1'(freq);
    v.fptr = 4'(fptr); v.pv = 1'(pv);       v.pptr = 4'(pptr);  v.e_pop = 1'(ep);
    v.e_vld = 1'(ev);  v.e_aptr = 4'(ea);   v.e_cnt = 3'(ec);   v.e_push = 1'(eps);
    v.e_pu = 4'(epu);  v.e_err = 1'(ee);
    return v;
  endfunction

  // Model state: prefetched pointers as a queue, outstanding pops as a count.
  int m_mode;  // 0 = waiting for queue, 1 = serving, 2 = returning everything
  int m_q[$];
  int m_inf, m_pu, m_aptr;
  bit m_err, m_push, m_vld;

  // Free-queue and client emulation.
  int pool[$], held[$], ret_due[$], ret_ptr[$];
  int cyc, last_due, lat_lo, lat_hi, force_ptr, max_cnt;
  bit force_po;
  int log_push[$], hist_busy[$], hist_pop[$], hist_push[$];
  bit st_fq, st_areq, st_freq, st_flush;
  int st_fptr;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    fq_ready = 0; freecnt = 0; po_pvld = 0; po_ptr = 0;
    alloc_req = 0; free_req = 0; free_ptr = 0; flush = 0;
    m_mode = 0; m_q.delete(); m_inf = 0; m_pu = 0; m_aptr = 0;
    m_err = 0; m_push = 0; m_vld = 0;
    pool.delete(); held.delete(); ret_due.delete(); ret_ptr.delete();
    log_push.delete(); hist_busy.delete(); hist_pop.delete(); hist_push.delete();
    cyc = 0; last_due = -1; lat_lo = 1; lat_hi = 1; force_po = 0; force_ptr = 0; max_cnt = 0;
    st_fq = 0; st_areq = 0; st_freq = 0; st_flush = 0; st_fptr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step();
    bit e_pop, deq, fpush, drained, pv;
    int pp, due;
    @(negedge clk);
    pv = force_po || (ret_due.size() > 0 && ret_due[0] == cyc);
    pp = force_po ? force_ptr : (pv ? ret_ptr[0] : 0);
    fq_ready = st_fq; freecnt = 5'(pool.size()); alloc_req = st_areq;
    free_req = st_freq; free_ptr = 4'(st_fptr); flush = st_flush;
    po_pvld = pv; po_ptr = 4'(pp);
    e_pop = (m_mode == 1) && st_fq && (m_q.size() + m_inf < P) && (pool.size() > m_inf);
    #1;
    check("pop", int'(pop), int'(e_pop));
    check("alloc_vld", int'(alloc_vld), int'(m_vld));
    if (m_vld) check("alloc_ptr", int'(alloc_ptr), m_aptr);
    check("push", int'(push), int'(m_push));
    if (m_push) check("pu_ptr", int'(pu_ptr), m_pu);
    check("busy", int'(busy), int'(m_mode == 2));
    check("pf_cnt", int'(pf_cnt), m_q.size());
    check("err", int'(err), int'(m_err));
    hist_push.push_back(int'(push)); hist_busy.push_back(int'(busy)); hist_pop.push_back(int'(pop));
    if (push) log_push.push_back(int'(pu_ptr));
    if (int'(pf_cnt) > max_cnt) max_cnt = int'(pf_cnt);

    // Free queue: pop leaves the pool, push rejoins it, pops return in order.
    if (e_pop) begin
      due = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      ret_due.push_back(due);
      ret_ptr.push_back(pool.pop_front());
    end
    if (m_push) pool.push_back(m_pu);
    if (pv && !force_po) begin
      void'(ret_due.pop_front());
      void'(ret_ptr.pop_front());
    end

    deq     = st_areq && m_vld;
    fpush   = (m_mode == 2) && (m_inf == 0) && (m_q.size() > 0) && !st_freq;
    drained = (m_q.size() == 0) && (m_inf == 0);
    if (st_areq && !m_vld) m_err = 1;
    if (st_freq)    begin m_push = 1; m_pu = st_fptr; end
    else if (fpush) begin m_push = 1; m_pu = m_q[0]; end
    else            m_push = 0;
    if (deq) held.push_back(m_q[0]);
    if (deq || fpush) void'(m_q.pop_front());
    if (pv) begin
      if (m_inf == 0) m_err = 1;
      else begin
        m_inf--;
        if (m_q.size() < P) m_q.push_back(pp);
        else m_err = 1;
      end
    end
    if (e_pop) m_inf++;
    case (m_mode)
      0: if (st_fq) m_mode = 1;
      1: if (st_flush) m_mode = 2;
      2: if (drained) m_mode = 1;
      default: m_mode = 0;
    endcase
    m_vld = (m_q.size() > 0) && (m_mode == 1);
    if (m_q.size() > 0) m_aptr = m_q[0];
    cyc++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    rst = 1'b0;
    do_reset();
    check("rst_pu_ptr", int'(pu_ptr), 0);
    check("rst_busy", int'(busy), 0);

    // Init, four prefetches with 2-cycle return latency, then dequeue/return/simultaneous events.
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,16,0,0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(1,16,0,0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(1,16,0,0,0,0,0, 1,0,0,0,0,0,0));
    tbl.push_back(mk(1,16,0,0,0,0,0, 1,0,0,0,0,0,0));
    tbl.push_back(mk(1,16,0,0,0,1,0, 1,0,0,0,0,0,0));
    tbl.push_back(mk(1,16,0,0,0,1,1, 1,1,0,1,0,0,0));
    tbl.push_back(mk(1,16,0,0,0,1,2, 0,1,0,2,0,0,0));
    tbl.push_back(mk(1,16,0,0,0,1,3, 0,1,0,3,0,0,0));
    tbl.push_back(mk(1,16,0,0,0,0,0, 0,1,0,4,0,0,0));
    tbl.push_back(mk(1,16,1,1,7,0,0, 0,1,0,4,0,0,0));
    tbl.push_back(mk(1,16,0,0,0,0,0, 1,1,1,3,1,7,0));
    tbl.push_back(mk(1,16,1,0,0,1,4, 0,1,1,3,0,0,0));
    tbl.push_back(mk(1,16,0,0,0,0,0, 1,1,2,3,0,0,0));
    tbl.push_back(mk(1,16,1,0,0,0,0, 0,1,2,3,0,0,0));
    tbl.push_back(mk(1,16,0,0,0,0,0, 1,1,3,2,0,0,0));
    foreach (tbl[i]) begin
      @(negedge clk);
      fq_ready = tbl[i].fq; freecnt = tbl[i].fc; alloc_req = tbl[i].areq;
      free_req = tbl[i].freq; free_ptr = tbl[i].fptr; po_pvld = tbl[i].pv;
      po_ptr = tbl[i].pptr; flush = 1'b0;
      #1;
      check($sformatf("vec%0d_pop", i), int'(pop), int'(tbl[i].e_pop));
      check($sformatf("vec%0d_alloc_vld", i), int'(alloc_vld), int'(tbl[i].e_vld));
      check($sformatf("vec%0d_alloc_ptr", i), int'(alloc_ptr), int'(tbl[i].e_aptr));
      check($sformatf("vec%0d_pf_cnt", i), int'(pf_cnt), int'(tbl[i].e_cnt));
      check($sformatf("vec%0d_push", i), int'(push), int'(tbl[i].e_push));
      if (tbl[i].e_push) check($sformatf("vec%0d_pu_ptr", i), int'(pu_ptr), int'(tbl[i].e_pu));
      check($sformatf("vec%0d_err", i), int'(err), int'(tbl[i].e_err));
      check($sformatf("vec%0d_busy", i), int'(busy), 0);
    end

    // Steady allocation: pointers come out in free-queue order.
    do_reset();
    for (int i = 0; i < 16; i++) pool.push_back(i);
    lat_lo = 2; lat_hi = 2; st_fq = 1;
    for (int i = 0; i < 120; i++) begin
      st_areq = m_vld;
      step();
    end
    check("steady_count", held.size(), 16);
    for (int i = 0; i < 16 && i < held.size(); i++) check($sformatf("steady_seq%0d", i), held[i], i);

    // Low free count, then more pointers become free.
    do_reset();
    pool.push_back(0);
    lat_lo = 1; lat_hi = 3; st_fq = 1;
    repeat (12) step();
    check("low_max_cnt", max_cnt, 1);
    pool.push_back(1); pool.push_back(2);
    repeat (20) step();
    check("low_refill_cnt", max_cnt, 3);

    // Flush while a client return is in the same cycle.
    do_reset();
    pool.push_back(9); pool.push_back(10); pool.push_back(11);
    lat_lo = 2; lat_hi = 2; st_fq = 1;
    for (int i = 0; i < 40 && !(m_q.size() == 3 && m_inf == 0 && pool.size() == 0); i++) step();
    check("flush_setup_cnt", m_q.size(), 3);
    step();
    check("flush_setup_head", int'(alloc_ptr), 9);
    log_push.delete(); hist_push.delete(); hist_busy.delete(); hist_pop.delete();
    st_flush = 1; st_freq = 1; st_fptr = 5;
    step();
    st_flush = 0; st_freq = 0;
    repeat (10) step();
    check("flush_push_count", log_push.size(), 4);
    if (log_push.size() == 4) begin
      check("flush_push0", log_push[0], 5);
      check("flush_push1", log_push[1], 9);
      check("flush_push2", log_push[2], 10);
      check("flush_push3", log_push[3], 11);
    end
    last = -1;
    foreach (hist_push[i]) if (hist_push[i] != 0) last = i;
    if (last < 0 || last + 1 >= hist_busy.size()) check("flush_last_push_seen", 0, 1);
    else begin
      check("flush_busy_at_last", hist_busy[last], 1);
      check("flush_busy_after", hist_busy[last + 1], 0);
      check("flush_pop_resume", hist_pop[last + 1], 1);
    end

    // Allocation from an empty FIFO is a sticky error.
    do_reset();
    st_fq = 1;
    repeat (2) step();
    st_areq = 1;
    step();
    st_areq = 0;
    repeat (4) step();
    check("empty_alloc_err", int'(err), 1);

    // Return with nothing in flight is dropped and flagged.
    do_reset();
    st_fq = 1;
    step();
    force_po = 1; force_ptr = 6;
    step();
    force_po = 0;
    repeat (2) step();
    check("spurious_err", int'(err), 1);
    check("spurious_cnt", int'(pf_cnt), 0);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 16; i++) pool.push_back(i);
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 1500; i++) begin
      st_fq    = (m_mode == 0) ? ($urandom_range(3) != 0) : ($urandom_range(15) != 0);
      st_areq  = m_vld && ($urandom_range(1) == 1);
      st_freq  = 0;
      if (held.size() > 0 && $urandom_range(2) == 0) begin
        st_freq = 1;
        st_fptr = held.pop_front();
      end
      st_flush = ($urandom_range(29) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
